// File: rtl/tx_seq_pkg.sv
// Shared definitions for the transmit FIFO write sequencer.
//   tx_state_e   : sequencer FSM states (IDLE, RUN, DONE)
//   *_W_DEF      : default address, data and burst-length widths
package tx_seq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/tx_addr_counter.sv
// Loadable, enabled, wrapping address counter driving the ROM read address.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   load        : load load_value (takes priority over en)
//   load_value  : value to load
//   en          : increment by one, wrapping modulo 2^ADDR_W
//   count       : registered counter value
module tx_addr_counter
  import tx_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              en,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      // natural overflow gives the modulo-2^ADDR_W wrap
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tx_fifo_write_sequencer.sv
// Streams a programmed burst of words from the transmit pattern ROM into the
// FIFO write port. Started by a one-cycle start strobe while idle; honours
// fifo_full, pause and abort. Single (write) clock domain.
// Ports:
//   wr_clk, wr_rst_n          : clock, asynchronous active-low reset
//   start, start_addr, length : burst command (sampled only in IDLE)
//   pause, abort              : stall / terminate an active burst
//   fifo_full                 : FIFO full flag
//   rom_addr, rom_data        : registered ROM address, combinational ROM data
//   fifo_wr_en, fifo_wr_data  : FIFO write port
//   busy, done, aborted       : status (RUN level, completion pulse, abort pulse)
//   words_sent                : words written in the current or last burst
//   state_dbg                 : current FSM state, for observation only
//
// Write handshake: fifo_wr_en is the valid; !fifo_full is the ready. A word
// transfers on every rising edge where fifo_wr_en=1, and fifo_wr_en is never
// raised while fifo_full=1, so a transfer is exactly fifo_wr_en=1 at the edge.
module tx_fifo_write_sequencer
  import tx_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              pause,
  input  logic              abort,
  input  logic              fifo_full,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_sent,
  output tx_state_e         state_dbg
);

  tx_state_e        state;
  tx_state_e        state_next;
  logic [LEN_W-1:0] remaining;
  logic             start_fire;

  assign start_fire   = (state == ST_IDLE) && start;
  assign fifo_wr_data = rom_data;
  assign state_dbg    = state;

  tx_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk        (wr_clk),
    .rst_n      (wr_rst_n),
    .load       (start_fire),
    .load_value (start_addr),
    .en         (fifo_wr_en),
    .count      (rom_addr)
  );

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs. Inside RUN abort wins over stalls, stalls win
  // over the write.
  always_comb begin
    state_next = state;
    fifo_wr_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_next = ST_IDLE;
        end else if (!fifo_full && !pause) begin
          fifo_wr_en = 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // remaining and words_sent only move on a write, so an abort leaves
  // words_sent frozen at the count reached so far.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      remaining  <= '0;
      words_sent <= '0;
      aborted    <= 1'b0;
    end else begin
      aborted <= (state == ST_RUN) && abort;
      if (start_fire) begin
        remaining  <= length;
        words_sent <= '0;
      end else if (fifo_wr_en) begin
        remaining  <= remaining - 1'b1;
        words_sent <= words_sent + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_fifo_write_sequencer.sv
// Self-checking bench for tx_fifo_write_sequencer. A behavioural model walks
// each burst cycle by cycle: the word expected next is rom[start_addr+sent],
// a cycle with a stall or abort expects no write, and completion/abort
// pulses are expected one cycle after the last write or the abort.
module tb_tx_fifo_write_sequencer;
  import tx_seq_pkg::*;

  logic       wr_clk;
  logic       wr_rst_n;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic       pause;
  logic       abort;
  logic       fifo_full;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [8:0] words_sent;
  tx_state_e  state_dbg;

  logic [7:0] rom_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  assign rom_data = rom_mem[rom_addr];

  tx_fifo_write_sequencer dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .pause        (pause),
    .abort        (abort),
    .fifo_full    (fifo_full),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .words_sent   (words_sent),
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    pause      = 1'b0;
    abort      = 1'b0;
    fifo_full  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_aborted"}, 32'(aborted), 32'h0);
    chk({tag, "_words_sent"}, 32'(words_sent), 32'h0);
  endtask

  // Runs one burst issued in cycle 0. Cycle numbers follow the start cycle.
  // full_m/pause_m force stalls in the given cycles; stall_pct adds random
  // stalls; abort_cyc (0 = none) aborts in that cycle; noise drives random
  // start commands during RUN and start/abort during the DONE cycle, all of
  // which must be ignored. end_cyc returns the done or abort cycle.
  task automatic do_burst(input logic [7:0] sa, input int len, input int abort_cyc,
                          input logic [63:0] full_m, input logic [63:0] pause_m,
                          input int stall_pct, input bit noise,
                          output int end_cyc, output int sent_out);
    int         cyc;
    int         sent;
    bit         fin;
    logic       f;
    logic       p;
    logic [7:0] exp_addr;
    cyc = 0;
    sent = 0;
    fin = 1'b0;
    end_cyc = -1;
    @(negedge wr_clk);
    idle_inputs();
    start      = 1'b1;
    start_addr = sa;
    length     = 9'(len);
    #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_wr_en", 32'(fifo_wr_en), 32'h0);
    while (!fin) begin
      @(negedge wr_clk);
      cyc++;
      start      = noise;
      start_addr = 8'($urandom);
      length     = 9'($urandom_range(1, 20));
      abort      = 1'b0;
      fifo_full  = 1'b0;
      pause      = 1'b0;
      if (cyc > 400) begin
        chk("burst_timeout", 32'h1, 32'h0);
        fin = 1'b1;
      end else if (sent == len) begin
        abort = noise;
        #1;
        chk("done_pulse", 32'(done), 32'h1);
        chk("done_busy", 32'(busy), 32'h0);
        chk("done_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("done_words_sent", 32'(words_sent), 32'(len));
        end_cyc = cyc;
        @(negedge wr_clk);
        idle_inputs();
        #1;
        chk("post_done_done", 32'(done), 32'h0);
        chk("post_done_aborted", 32'(aborted), 32'h0);
        chk("post_done_busy", 32'(busy), 32'h0);
        fin = 1'b1;
      end else if (cyc == abort_cyc) begin
        abort = 1'b1;
        f = ($urandom_range(0, 1) == 1);
        fifo_full = f;
        #1;
        chk("abort_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("abort_busy", 32'(busy), 32'h1);
        end_cyc = cyc;
        @(negedge wr_clk);
        idle_inputs();
        #1;
        chk("aborted_pulse", 32'(aborted), 32'h1);
        chk("aborted_busy", 32'(busy), 32'h0);
        chk("aborted_done", 32'(done), 32'h0);
        chk("aborted_words_sent", 32'(words_sent), 32'(sent));
        @(negedge wr_clk);
        #1;
        chk("post_abort_aborted", 32'(aborted), 32'h0);
        chk("post_abort_done", 32'(done), 32'h0);
        fin = 1'b1;
      end else begin
        f = ((cyc < 64) ? full_m[cyc] : 1'b0) || ($urandom_range(0, 99) < stall_pct);
        p = ((cyc < 64) ? pause_m[cyc] : 1'b0) || ($urandom_range(0, 99) < stall_pct);
        fifo_full = f;
        pause     = p;
        #1;
        chk("run_busy", 32'(busy), 32'h1);
        chk("run_done", 32'(done), 32'h0);
        chk("run_words_sent", 32'(words_sent), 32'(sent));
        if (f || p) begin
          chk("stall_wr_en", 32'(fifo_wr_en), 32'h0);
        end else begin
          exp_addr = sa + 8'(sent);
          chk("write_wr_en", 32'(fifo_wr_en), 32'h1);
          chk("write_rom_addr", 32'(rom_addr), 32'(exp_addr));
          chk("write_data", 32'(fifo_wr_data), 32'(rom_mem[exp_addr]));
          sent++;
        end
      end
    end
    idle_inputs();
    sent_out = sent;
  endtask

  initial begin
    int end_cyc;
    int sent;
    int len;
    int ab;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    idle_inputs();

    // reset state
    wr_rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge wr_clk);
    wr_rst_n = 1'b1;

    // 4 words from 0x10, no stalls: done in cycle 5
    do_burst(8'h10, 4, 0, 64'h0, 64'h0, 0, 1'b0, end_cyc, sent);
    chk("basic_done_cycle", 32'(end_cyc), 32'd5);
    chk("basic_sent", 32'(sent), 32'd4);

    // address wrap 0xFE..0x01
    do_burst(8'hFE, 4, 0, 64'h0, 64'h0, 0, 1'b0, end_cyc, sent);
    chk("wrap_done_cycle", 32'(end_cyc), 32'd5);

    // full in cycles 3-5, pause in cycle 7: done in cycle 13
    do_burst(8'h40, 8, 0, 64'h38, 64'h80, 0, 1'b0, end_cyc, sent);
    chk("stall_done_cycle", 32'(end_cyc), 32'd13);
    chk("stall_sent", 32'(sent), 32'd8);

    // zero length: done in cycle 1 with no writes
    do_burst(8'h22, 0, 0, 64'h0, 64'h0, 0, 1'b0, end_cyc, sent);
    chk("zero_done_cycle", 32'(end_cyc), 32'd1);

    // starts while busy / in DONE are ignored; abort in DONE is ignored
    do_burst(8'h80, 6, 0, 64'h0, 64'h0, 20, 1'b1, end_cyc, sent);
    chk("noise_sent", 32'(sent), 32'd6);

    // 10 words, abort in cycle 4
    do_burst(8'h30, 10, 4, 64'h0, 64'h0, 0, 1'b0, end_cyc, sent);
    chk("abort_cycle", 32'(end_cyc), 32'd4);
    chk("abort_sent", 32'(sent), 32'd3);

    // maximum length 256 wraps the full address space
    do_burst(8'($urandom), 256, 0, 64'h0, 64'h0, 0, 1'b0, end_cyc, sent);
    chk("max_done_cycle", 32'(end_cyc), 32'd257);

    // randomized bursts with random stalls, noise and occasional abort
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 40);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      do_burst(8'($urandom), len, ab, 64'h0, 64'h0, $urandom_range(0, 40),
               1'($urandom_range(0, 1)), end_cyc, sent);
    end

    // asynchronous reset in the middle of a burst
    @(negedge wr_clk);
    start      = 1'b1;
    start_addr = 8'h55;
    length     = 9'd20;
    @(negedge wr_clk);
    start = 1'b0;
    repeat (3) @(negedge wr_clk);
    #2;
    wr_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    idle_inputs();
    do_burst(8'hC3, 5, 0, 64'h0, 64'h0, 10, 1'b0, end_cyc, sent);
    chk("after_reset_sent", 32'(sent), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
